// File: rtl/ps2_rx_fifo_if.sv
// Read-side handshake and status bundle of the PS/2 receive FIFO.
interface ps2_rx_fifo_if;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  // Consumer side: strobes nextdata_n, observes head byte and flags.
  modport master (
    output nextdata_n,
    input  data,
    input  ready,
    input  overflow,
    input  frame_err
  );

  // Receiver side: drives head byte and flags, accepts the read strobe.
  modport slave (
    input  nextdata_n,
    output data,
    output ready,
    output overflow,
    output frame_err
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: line synchronisers, 11-bit frame
// deserialiser with start/parity/stop checks, partial-frame timeout,
// and a small circular FIFO read through a ready/nextdata_n handshake.
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_rx_fifo_if.slave  rd
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [2:0]       clk_sync_q;
  logic [1:0]       dat_sync_q;
  logic             fall;
  logic             data_s;

  logic [3:0]       cnt_q, cnt_d;
  logic [9:0]       sh_q, sh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             frame_done;
  logic             good;
  logic             bad;
  logic [7:0]       rx_byte;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             overflow_q, overflow_d;
  logic             frame_err_q;

  // Two-flop synchronisers; the extra clock-path flop remembers the previous level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
    end
  end

  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_s = dat_sync_q[1];

  // Bit counter, shift register and partial-frame timeout.
  always_comb begin
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    to_d       = to_q;
    frame_done = 1'b0;
    if (fall) begin
      to_d = '0;
      if (cnt_q == 4'd10) begin
        cnt_d      = 4'd0;
        sh_d       = '0;
        frame_done = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
        sh_d  = {data_s, sh_q[9:1]};
      end
    end else if (cnt_q == 4'd0) begin
      to_d = '0;
    end else if (to_q == TO_LAST) begin
      to_d  = '0;
      cnt_d = 4'd0;
      sh_d  = '0;
    end else begin
      to_d = to_q + TO_W'(1);
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
      sh_q  <= '0;
      to_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
      to_q  <= to_d;
    end
  end

  // sh_q[0] is the start bit, sh_q[8:1] the byte, sh_q[9] parity; stop is live.
  assign rx_byte = sh_q[8:1];
  assign good    = frame_done & ~sh_q[0] & data_s & (^sh_q[9:1]);
  assign bad     = frame_done & ~good;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]) &
                 (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]);

  // A pop in the same cycle frees the slot the push writes into.
  assign pop  = ~empty & ~rd.nextdata_n;
  assign push = good & (~full | pop);

  // Pointer and overflow next-state.
  always_comb begin
    wr_d       = wr_q + PTR_W'(push);
    rd_d       = rd_q + PTR_W'(pop);
    overflow_d = overflow_q;
    if (pop) begin
      overflow_d = 1'b0;
    end else if (good && full) begin
      overflow_d = 1'b1;
    end
  end

  // FIFO pointers and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q        <= '0;
      rd_q        <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      overflow_q  <= overflow_d;
      frame_err_q <= bad;
    end
  end

  // FIFO storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[DEPTH_LOG2-1:0]] <= rx_byte;
    end
  end

  assign rd.ready     = ~empty;
  assign rd.data      = empty ? 8'h00 : mem_q[rd_q[DEPTH_LOG2-1:0]];
  assign rd.overflow  = overflow_q;
  assign rd.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo with a queue-based reference model.
module tb_ps2_rx_fifo;
  localparam int TO   = 300;
  localparam int HALF = 20;
  localparam int DEP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_rx_fifo_if bus ();

  ps2_rx_fifo #(.DEPTH_LOG2(3), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rd       (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ferr_seen = 0;
  int ferr_exp = 0;
  logic [7:0] mq[$];
  bit movf = 1'b0;

  always @(negedge clk) if (bus.frame_err === 1'b1) ferr_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    #1;
    chk({tag, ".ready"}, {31'd0, bus.ready}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) chk({tag, ".data"}, {24'd0, bus.data}, {24'd0, mq[0]});
    chk({tag, ".overflow"}, {31'd0, bus.overflow}, {31'd0, movf});
    chk({tag, ".frame_err_count"}, ferr_seen, ferr_exp);
  endtask

  // kind: 0 good, 1 parity error, 2 stop error, 3 start error.
  // mode: 0 plain, 1 pop strobed at the push edge, 2 check push latency.
  task automatic send(input logic [7:0] b, input int kind, input int mode);
    logic [10:0] f;
    f[0]   = (kind == 3);
    f[8:1] = b;
    f[9]   = (~^b) ^ (kind == 1);
    f[10]  = (kind != 2);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (2) @(negedge clk);
        bus.nextdata_n = 1'b0;
        @(negedge clk);
        bus.nextdata_n = 1'b1;
        repeat (HALF - 3) @(negedge clk);
      end else if (i == 10 && mode == 2) begin
        @(posedge clk); @(posedge clk); #1;
        chk("latency.ready_early", {31'd0, bus.ready}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("latency.ready_4cyc", {31'd0, bus.ready}, 32'd1);
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    if (mode == 1 && mq.size() != 0) begin
      void'(mq.pop_front());
      movf = 1'b0;
    end
    if (kind == 0) begin
      if (mq.size() < DEP) mq.push_back(b);
      else movf = 1'b1;
    end else begin
      ferr_exp++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic pop1();
    @(negedge clk);
    bus.nextdata_n = 1'b0;
    @(negedge clk);
    bus.nextdata_n = 1'b1;
    if (mq.size() != 0) begin
      void'(mq.pop_front());
      movf = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = mq.size();
    for (int i = 0; i < n; i++) begin
      pop1();
      check_state(tag);
    end
  endtask

  initial begin
    logic [7:0] rb;
    int kind;
    int mode;
    int npop;

    bus.nextdata_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset.ready", {31'd0, bus.ready}, 32'd0);
    chk("reset.overflow", {31'd0, bus.overflow}, 32'd0);
    chk("reset.frame_err", {31'd0, bus.frame_err}, 32'd0);
    chk("reset.data", {24'd0, bus.data}, 32'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte with latency check, then one-cycle read.
    send(8'h1C, 0, 2);
    check_state("single");
    pop1();
    check_state("single.pop");

    // Back-to-back frames read in order.
    send(8'h1C, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h1C, 0, 0);
    check_state("b2b");
    drain("b2b.drain");

    // Parity error, then a good frame.
    send(8'h1C, 1, 0);
    check_state("parity_err");
    send(8'h1C, 0, 0);
    check_state("after_err");
    drain("after_err.drain");

    // Overflow on the ninth byte.
    for (int i = 0; i < 9; i++) send(8'(i), 0, 0);
    check_state("overflow");
    pop1();
    check_state("overflow.pop");
    drain("overflow.drain");

    // Full FIFO with a pop at the push edge: push succeeds, no overflow.
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 0, 0);
    send(8'h18, 0, 1);
    check_state("full_pop_push");
    drain("full_pop_push.drain");
    pop1();
    check_state("empty_pop_ignored");

    // Partial frame abandoned by timeout.
    send_bits(5);
    repeat (TO + 10) @(negedge clk);
    send(8'h1C, 0, 0);
    check_state("timeout");
    drain("timeout.drain");

    // Randomised frames, errors and reads.
    for (int it = 0; it < 24; it++) begin
      rb   = 8'($urandom_range(0, 255));
      kind = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 3)) : 0;
      mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      send(rb, kind, mode);
      check_state("rand.frame");
      npop = int'($urandom_range(0, 1));
      for (int k = 0; k < npop; k++) begin
        pop1();
        check_state("rand.pop");
      end
    end
    drain("rand.drain");

    // Reset mid-frame with bytes queued.
    for (int i = 0; i < 3; i++) send(8'(8'hA0 + i), 0, 0);
    send_bits(6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.ready", {31'd0, bus.ready}, 32'd0);
    chk("midrst.overflow", {31'd0, bus.overflow}, 32'd0);
    mq.delete();
    movf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h2E, 0, 0);
    check_state("midrst.next");
    drain("midrst.drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 device-to-host receiver feeding the keyboard display/monitor stage.
- Synchronises the raw PS/2 clock and data lines and detects falling edges of the PS/2 clock.
- Deserialises 11-bit frames, checks start, parity and stop bits, and buffers good bytes in a small FIFO.
- Presents the FIFO head with a ready/nextdata_n read handshake; the consumer may hold nextdata_n = ~ready to drain continuously.

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (8).
- TIMEOUT, 50000, clk cycles with no PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous to clk.
- ps2_data  in  1  raw PS/2 data line, asynchronous to clk.
- nextdata_n  in  1  active-low read strobe; pops the head when low while ready=1.
- data  out  8  FIFO head byte; valid only while ready=1.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky flag: a good byte was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse: the received frame failed start, parity or stop check.

Behaviour:
- Reset (async, rst=1) clears:
  - sync flops to 1;
  - bit counter, shift register, timeout counter, rd/wr pointers to 0;
  - ready=0, overflow=0, frame_err=0, data=8'h00.
- Synchronisation: ps2_clk and ps2_data each pass through 2 flops. A third flop on the clock path gives fall = prev & ~cur, asserted for one clk cycle. Data is sampled from its synchronised value in the fall cycle.
- Frame format: bit0 start=0, bits1-8 data LSB first, bit9 odd parity, bit10 stop=1. The bit counter runs 0..10 and increments on each fall.
- Frame completion: on the fall with count=10, evaluate the frame and return count to 0.
  - Good frame: start==0, stop==1, and XOR of (8 data bits, parity) ==1. Push the byte into the FIFO at that clock edge.
  - Bad frame: discard the byte, pulse frame_err=1 on the following cycle, no FIFO change.
- Timeout: while count!=0, a counter runs and is cleared on every fall. When it reaches TIMEOUT-1, reset count to 0 and discard the partial frame. No frame_err on timeout. The counter is held at 0 while count==0.
- FIFO: circular buffer with DEPTH_LOG2+1-bit pointers.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2**(DEPTH_LOG2+1).
- Read handshake: pop happens on a posedge where ready=1 and nextdata_n=0. data is combinational from the head entry. Next head is visible the cycle after a pop. nextdata_n=0 while ready=0 is ignored.
- Latency: ps2_clk falling pin edge to fall pulse is 3 clk cycles. ready rises the cycle after the push edge.
- Simultaneous push and pop:
  - Not full: both occur; occupancy unchanged.
  - Full: pop is honoured first and push succeeds; overflow is not set.
  - Empty: only push occurs.
- Overflow:
  - Good frame arrives while full with no pop that cycle: byte dropped, FIFO contents intact, overflow=1.
  - overflow clears on the next successful pop.
  - If a pop and an overflow-setting event coincide, the pop-plus-push rule applies, so overflow stays 0.
- Glitches: no debounce beyond synchronisation. A spurious fall is treated as a bit, and the resulting frame error or timeout recovers alignment.

Test Plan:
- Send 0x1C as bits 0,0,0,1,1,1,0,0,0,0,1 at 10 kHz -> ready=1 and data=8'h1C 4 cycles after the 11th falling pin edge; nextdata_n pulsed low one cycle -> ready=0.
- Send 0x1C, 0xF0 (parity=1), 0x1C back-to-back with nextdata_n=1 -> reads return 8'h1C, 8'hF0, 8'h1C in order, then ready=0.
- Send 0x1C with parity=1 -> frame_err pulses once, ready stays 0. Then send 0x1C correctly -> data=8'h1C.
- Send 9 good bytes 0x00..0x08 with no reads -> overflow=1, FIFO holds 0x00..0x07. First pop -> overflow=0, data=8'h01.
- Send 5 bits, then idle for TIMEOUT cycles, then send a full 0x1C frame -> no frame_err, data=8'h1C.
- Assert rst mid-frame (after 6 bits) with 3 bytes queued -> ready=0 and overflow=0 immediately. The next full frame 0x2E -> data=8'h2E.
